// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline types: per-stage payload bundles, default buffer depth
// and the circular-buffer pointer wrap helper.
package cpu_pipe_pkg;

  localparam int PIPE_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fede_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } deex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
  } exme_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_we;
  } mewb_t;

  // Wraps at depth-1 so non-power-of-two depths never index past the array.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// DEPTH x DATA_W storage for the stage buffer: one synchronous write port,
// asynchronous read port; contents are never reset.
module pipe_buf_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_ptr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_ptr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_ptr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage register: valid/ready circular buffer, 1-cycle latency,
// in_ready = !full (state only), stall freezes output, flush drops and counts.
module pipe_stage_buf
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = PIPE_DEPTH_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       stall,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  // Headroom for drop_cnt + up to DEPTH+1 dropped beats before saturating.
  localparam int SUM_W = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [SUM_W-1:0] drop_sum;
  logic             push;
  logic             pop;

  always_comb begin
    in_ready   = (count_q != OCC_W'(DEPTH));
    out_valid  = (count_q != '0) && !stall;
    push       = in_valid && in_ready && !flush;
    pop        = out_valid && out_ready && !flush;
    drop_sum   = SUM_W'(drop_cnt_q) + SUM_W'(count_q) + SUM_W'(in_valid && in_ready);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
    end else begin
      if (push) begin
        wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
      end
      if (pop) begin
        rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
      end
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign occupancy = count_q;
  assign drop_cnt  = drop_cnt_q;

  pipe_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr_q),
    .wr_data (in_data),
    .rd_ptr  (rd_ptr_q),
    .rd_data (out_data)
  );

endmodule
